// File: rtl/trap_controller_if.sv
// rtl/trap_controller_if.sv - pipeline-side bus of the machine-mode trap controller
interface trap_controller_if;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        irq_ext;
    logic        irq_timer;
    logic        drained;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport master (
        output instr_valid, instr_pc, ecall, ebreak, mret,
        output csr_en, csr_op, csr_addr, csr_wdata,
        output irq_ext, irq_timer, drained,
        input  csr_rdata, flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  instr_valid, instr_pc, ecall, ebreak, mret,
        input  csr_en, csr_op, csr_addr, csr_wdata,
        input  irq_ext, irq_timer, drained,
        output csr_rdata, flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - M-mode trap sequencer with trap CSRs and pipeline drain/redirect
module trap_controller #(
    parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
    parameter int          IRQ_SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    trap_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_COMMIT,
        ST_REDIRECT
    } state_e;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;

    state_e state_q, state_d;

    logic [IRQ_SYNC_STAGES-1:0] ext_sync_q;
    logic [IRQ_SYNC_STAGES-1:0] tim_sync_q;
    logic irq_ext_s, irq_tim_s;

    logic        st_mie_q,  st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    logic [31:2] mtvec_q,  mtvec_d;
    logic [31:1] mepc_q,   mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic [31:1] epc_q,    epc_d;
    logic [31:0] cause_q,  cause_d;
    logic        is_mret_q, is_mret_d;

    logic [31:0] csr_rdata;
    logic [31:0] csr_new;
    logic        csr_we;
    logic        ext_pend, tim_pend, irq_take;
    logic        exc_evt, event_any;
    logic [31:0] evt_cause;

    logic        flush, busy, redirect_valid;
    logic [31:0] redirect_pc;
    logic        unused_pc0;

    assign unused_pc0 = bus.instr_pc[0];

    // Interrupt lines are asynchronous; only the last stage is observed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_sync_q <= '0;
            tim_sync_q <= '0;
        end else begin
            ext_sync_q[0] <= bus.irq_ext;
            tim_sync_q[0] <= bus.irq_timer;
            for (int i = 1; i < IRQ_SYNC_STAGES; i++) begin
                ext_sync_q[i] <= ext_sync_q[i-1];
                tim_sync_q[i] <= tim_sync_q[i-1];
            end
        end
    end

    assign irq_ext_s = ext_sync_q[IRQ_SYNC_STAGES-1];
    assign irq_tim_s = tim_sync_q[IRQ_SYNC_STAGES-1];

    always_comb begin
        csr_rdata = '0;
        case (bus.csr_addr)
            A_MSTATUS: begin
                csr_rdata[3] = st_mie_q;
                csr_rdata[7] = st_mpie_q;
            end
            A_MIE: begin
                csr_rdata[7]  = mie_mtie_q;
                csr_rdata[11] = mie_meie_q;
            end
            A_MTVEC:  csr_rdata = {mtvec_q, 2'b00};
            A_MEPC:   csr_rdata = {mepc_q, 1'b0};
            A_MCAUSE: csr_rdata = mcause_q;
            A_MIP: begin
                csr_rdata[7]  = irq_tim_s;
                csr_rdata[11] = irq_ext_s;
            end
            default:  csr_rdata = '0;
        endcase
    end

    always_comb begin
        case (bus.csr_op)
            2'b01:   csr_new = bus.csr_wdata;
            2'b10:   csr_new = csr_rdata | bus.csr_wdata;
            2'b11:   csr_new = csr_rdata & ~bus.csr_wdata;
            default: csr_new = csr_rdata;
        endcase
    end

    assign ext_pend  = mie_meie_q & irq_ext_s;
    assign tim_pend  = mie_mtie_q & irq_tim_s;
    assign irq_take  = st_mie_q & (ext_pend | tim_pend);
    assign exc_evt   = bus.ecall | bus.ebreak | irq_take;
    assign event_any = bus.instr_valid & (exc_evt | bus.mret);

    always_comb begin
        if (bus.ecall)       evt_cause = 32'd11;
        else if (bus.ebreak) evt_cause = 32'd3;
        else if (ext_pend)   evt_cause = 32'h8000_000B;
        else                 evt_cause = 32'h8000_0007;
    end

    // A CSR instruction that coincides with a trap event never retires.
    assign csr_we = (state_q == ST_RUN) && bus.csr_en && (bus.csr_op != 2'b00) && !event_any;

    always_comb begin
        state_d        = state_q;
        st_mie_d       = st_mie_q;
        st_mpie_d      = st_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        is_mret_d      = is_mret_q;
        flush          = 1'b0;
        busy           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        case (state_q)
            ST_RUN: begin
                if (event_any) begin
                    state_d   = ST_DRAIN;
                    cause_d   = evt_cause;
                    epc_d     = bus.instr_pc[31:1];
                    is_mret_d = !exc_evt;
                end else if (csr_we) begin
                    case (bus.csr_addr)
                        A_MSTATUS: begin
                            st_mie_d  = csr_new[3];
                            st_mpie_d = csr_new[7];
                        end
                        A_MIE: begin
                            mie_mtie_d = csr_new[7];
                            mie_meie_d = csr_new[11];
                        end
                        A_MTVEC:  mtvec_d  = csr_new[31:2];
                        A_MEPC:   mepc_d   = csr_new[31:1];
                        A_MCAUSE: mcause_d = csr_new;
                        default: ;
                    endcase
                end
            end
            ST_DRAIN: begin
                flush = 1'b1;
                busy  = 1'b1;
                if (bus.drained) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                flush   = 1'b1;
                busy    = 1'b1;
                state_d = ST_REDIRECT;
                if (is_mret_q) begin
                    st_mie_d  = st_mpie_q;
                    st_mpie_d = 1'b1;
                end else begin
                    mepc_d    = epc_q;
                    mcause_d  = cause_q;
                    st_mpie_d = st_mie_q;
                    st_mie_d  = 1'b0;
                end
            end
            ST_REDIRECT: begin
                busy           = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = is_mret_q ? {mepc_q, 1'b0} : {mtvec_q, 2'b00};
                state_d        = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_mtie_q <= 1'b0;
            mie_meie_q <= 1'b0;
            mtvec_q    <= MTVEC_RESET[31:2];
            mepc_q     <= '0;
            mcause_q   <= '0;
            epc_q      <= '0;
            cause_q    <= '0;
            is_mret_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_mtie_q <= mie_mtie_d;
            mie_meie_q <= mie_meie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            is_mret_q  <= is_mret_d;
        end
    end

    assign bus.csr_rdata      = csr_rdata;
    assign bus.flush          = flush;
    assign bus.busy           = busy;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap sequencer for the RV32IC core.
- Takes decoded ECALL/EBREAK/MRET strobes and the external and timer interrupt lines, and drains the pipeline through a flush/drained handshake.
- Updates the M-mode trap CSRs, then issues a single-cycle PC redirect.
- Also owns the CSR read/write port used by CSRRW/CSRRS/CSRRC and the immediate forms; the immediate is already zero-extended into csr_wdata upstream.

Parameters:
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec (bits [1:0] forced 0, direct mode only).
- IRQ_SYNC_STAGES, 2: flop stages on irq_ext and irq_timer; legal values 1..3.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- instr_valid  in  1  EX-stage instruction valid (instruction boundary)
- instr_pc  in  32  PC of the EX-stage instruction
- ecall  in  1  EX instruction is ECALL
- ebreak  in  1  EX instruction is EBREAK
- mret  in  1  EX instruction is MRET
- csr_en  in  1  CSR instruction in EX
- csr_op  in  2  01 write, 10 set, 11 clear, 00 read-only
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1 value or zero-extended uimm
- csr_rdata  out  32  combinational old value of the CSR at csr_addr
- irq_ext  in  1  external interrupt level (asynchronous)
- irq_timer  in  1  timer interrupt level (asynchronous)
- drained  in  1  pipeline reports no older instruction in flight
- flush  out  1  kill IF/ID/EX and hold the PC
- redirect_valid  out  1  one-cycle PC load strobe
- redirect_pc  out  32  redirect target
- busy  out  1  FSM not in RUN

Behaviour:
- Reset values:
  - flush, redirect_valid, busy = 0; redirect_pc = 0.
  - mstatus.MIE = 0, MPIE = 0; mie = 0; mepc = 0; mcause = 0; mtvec = MTVEC_RESET; synchronizers cleared.
  - Reset mid-sequence returns the FSM to RUN in the same edge.
- CSR map:
  - 0x300 mstatus: only bits 3 (MIE) and 7 (MPIE) are writable; all other bits read 0.
  - 0x304 mie: only bits 7 (MTIE) and 11 (MEIE) are writable.
  - 0x305 mtvec: bits [1:0] read 0.
  - 0x341 mepc: bit 0 reads 0.
  - 0x342 mcause: fully writable.
  - 0x344 mip: read-only, bit 7 = synced timer, bit 11 = synced external; writes ignored.
  - Any other address reads 0 and ignores writes.
- CSR update: the write takes effect at the clock edge for which csr_en is high, in RUN only. new = wdata, old|wdata, or old&~wdata according to csr_op; op 00 does not write.
- Trap event, evaluated in RUN with instr_valid = 1. Priority, highest first:
  1. ecall: cause 11.
  2. ebreak: cause 3.
  3. Interrupt (only if MIE = 1), external before timer:
     - pending external (MEIE & synced irq_ext): cause 32'h8000_000B.
     - pending timer (MTIE & synced irq_timer): cause 32'h8000_0007.
  4. mret.
- Interrupts cancel the EX instruction; epc is always instr_pc. A CSR access in the same cycle as a trap event is suppressed.
- FSM states:
  - RUN: busy = 0.
    - On a trap event: latch cause and epc (or the mret flag), go to DRAIN, and assert flush from the next cycle.
  - DRAIN: flush = 1, busy = 1; wait for drained = 1.
    - If drained is already 1 on entry, spend exactly one cycle in DRAIN.
  - COMMIT: flush = 1, one cycle.
    - Trap: mepc <= {epc[31:1], 0}; mcause <= cause; MPIE <= MIE; MIE <= 0.
    - MRET: MIE <= MPIE; MPIE <= 1.
  - REDIRECT: one cycle, then RUN.
    - redirect_valid = 1, flush = 0.
    - redirect_pc = mtvec for a trap, mepc for MRET; the CSR values used are those after COMMIT.
- Minimum latency from event to redirect is 3 cycles (DRAIN, COMMIT, REDIRECT).
- Events arriving while busy are ignored; the pipeline is flushing.
- Interrupt levels are not latched. A request deasserted before the RUN-state sample is never taken.

Test Plan:
- Reset, then read mtvec, mstatus and mepc -> mtvec = MTVEC_RESET, mstatus = 0, mepc = 0; flush, redirect_valid and busy all 0.
- Write mtvec = 0x0000_0103, then ECALL at pc 0x0000_0040 with drained high on the 2nd DRAIN cycle -> redirect_valid pulses with redirect_pc = 0x0000_0100; mepc = 0x40; mcause = 11; MIE = 0 and MPIE = old MIE.
- MRET after the previous trap, with mepc rewritten to 0x0000_0046 -> redirect_pc = 0x46, MIE restored from MPIE, MPIE = 1; 3-cycle latency.
- Set MIE = 1 and MEIE = MTIE = 1, raise irq_ext and irq_timer together with instr_pc = 0x80 -> mcause = 0x8000_000B, mepc = 0x80; the timer interrupt is taken after a subsequent MRET.
- irq_timer high with MIE = 0 -> no trap and mip bit 7 = 1 after IRQ_SYNC_STAGES cycles. Then CSRRS mstatus with wdata 0x8 -> the trap is taken on the next valid instruction.
- EBREAK at the same time as csr_en writing mtvec -> cause 3 and mtvec unchanged. Also assert rst_n low during DRAIN -> FSM back to RUN with flush = 0 on the next edge.
